// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and types for the ALU control stage.
// Contents: ALU function codes, base opcodes, funct3/funct7 values,
// immediate-format enum, decoded-word struct and two small helpers
// (immediate generation, funct3 -> alufn mapping).
package riscv_pkg;

  localparam logic [3:0] ALUFN_ADD   = 4'b0000;
  localparam logic [3:0] ALUFN_SUB   = 4'b0001;
  localparam logic [3:0] ALUFN_PASSB = 4'b0011;
  localparam logic [3:0] ALUFN_OR    = 4'b0100;
  localparam logic [3:0] ALUFN_AND   = 4'b0101;
  localparam logic [3:0] ALUFN_XOR   = 4'b0111;
  localparam logic [3:0] ALUFN_SRL   = 4'b1000;
  localparam logic [3:0] ALUFN_SLL   = 4'b1001;
  localparam logic [3:0] ALUFN_SRA   = 4'b1010;
  localparam logic [3:0] ALUFN_SLT   = 4'b1101;
  localparam logic [3:0] ALUFN_JALR  = 4'b1110;
  localparam logic [3:0] ALUFN_SLTU  = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {IMM_Z, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  typedef struct packed {
    logic [3:0]  alufn;
    logic        sel_imm;
    logic        sel_pc;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_t t);
    case (t)
      IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   gen_imm = {i[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: gen_imm = 32'b0;
    endcase
  endfunction

  // alt selects the funct7=0x20 flavour (SUB for f3=000, SRA for f3=101)
  function automatic logic [3:0] f3_alufn(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  f3_alufn = alt ? ALUFN_SUB : ALUFN_ADD;
      F3_SLL:  f3_alufn = ALUFN_SLL;
      F3_SLT:  f3_alufn = ALUFN_SLT;
      F3_SLTU: f3_alufn = ALUFN_SLTU;
      F3_XOR:  f3_alufn = ALUFN_XOR;
      F3_SR:   f3_alufn = alt ? ALUFN_SRA : ALUFN_SRL;
      F3_OR:   f3_alufn = ALUFN_OR;
      default: f3_alufn = ALUFN_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational RV32I decoder: instruction word -> decoded word.
// Ports:
//   instr  in   32-bit instruction word
//   dec    out  decoded word (alufn, operand selects, imm, reg fields,
//               reg_we, illegal)
module alu_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic       writes;
  logic       sel_imm;
  logic       sel_pc;
  logic [3:0] fn;
  imm_t       ityp;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    legal   = 1'b0;
    writes  = 1'b0;
    sel_imm = 1'b0;
    sel_pc  = 1'b0;
    fn      = ALUFN_ADD;
    ityp    = IMM_Z;
    case (opc)
      OPC_OP: begin
        writes = 1'b1;
        if (f7 == F7_BASE) begin
          legal = 1'b1;
          fn    = f3_alufn(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) begin
          legal = 1'b1;
          fn    = f3_alufn(f3, 1'b1);
        end
      end
      OPC_OPIMM: begin
        writes  = 1'b1;
        sel_imm = 1'b1;
        ityp    = IMM_I;
        // funct7 only qualifies the shift forms; ADDI never becomes SUB
        case (f3)
          F3_SLL: begin
            legal = (f7 == F7_BASE);
            fn    = ALUFN_SLL;
          end
          F3_SR: begin
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            fn    = f3_alufn(f3, f7 == F7_ALT);
          end
          default: begin
            legal = 1'b1;
            fn    = f3_alufn(f3, 1'b0);
          end
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1; writes = 1'b1; sel_imm = 1'b1; ityp = IMM_U; fn = ALUFN_PASSB;
      end
      OPC_AUIPC: begin
        legal = 1'b1; writes = 1'b1; sel_imm = 1'b1; sel_pc = 1'b1; ityp = IMM_U;
      end
      OPC_JAL: begin
        legal = 1'b1; writes = 1'b1; sel_imm = 1'b1; sel_pc = 1'b1; ityp = IMM_J;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); writes = 1'b1; sel_imm = 1'b1; ityp = IMM_I;
        fn    = ALUFN_JALR;
      end
      OPC_LOAD: begin
        legal = 1'b1; writes = 1'b1; sel_imm = 1'b1; ityp = IMM_I;
      end
      OPC_STORE: begin
        legal = 1'b1; sel_imm = 1'b1; ityp = IMM_S;
      end
      OPC_BRANCH: begin
        legal = 1'b1; ityp = IMM_B; fn = ALUFN_SUB;
      end
      default: ;
    endcase
  end

  // Illegal words still carry their register fields but all control is neutral
  assign dec.alufn    = legal ? fn : ALUFN_ADD;
  assign dec.sel_imm  = legal & sel_imm;
  assign dec.sel_pc   = legal & sel_pc;
  assign dec.imm      = legal ? gen_imm(instr, ityp) : 32'b0;
  assign dec.rs1_addr = instr[19:15];
  assign dec.rs2_addr = instr[24:20];
  assign dec.rd_addr  = instr[11:7];
  assign dec.reg_we   = legal & writes & (instr[11:7] != 5'd0);
  assign dec.illegal  = ~legal;

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control issue stage: decodes RV32I words and holds them in a
// 2-entry skid buffer with valid/ready on both sides and a redirect flush.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 drop all held and incoming entries
//   in_valid/in_ready     fetch-side handshake (in_ready registered)
//   instr                 instruction word
//   out_valid/out_ready   execute-side handshake (out_valid registered)
//   alufn, sel_imm, sel_pc, imm, rs1_addr, rs2_addr, rd_addr,
//   reg_we, illegal       decoded fields of the head entry
module alu_ctrl_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alufn,
  output logic            sel_imm,
  output logic            sel_pc,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            reg_we,
  output logic            illegal
);

  localparam logic [1:0] FULL = DEPTH[1:0];

  dec_t       dec_p0;
  dec_t       buf_p1 [2];
  dec_t       head;
  logic       head_p1;
  logic       tail_p1;
  logic [1:0] count_p1;
  logic [1:0] count_nxt;
  logic       in_ready_p1;
  logic       vld_p1;
  logic       push;
  logic       pop;

  // ---- stage 0: combinational decode of the incoming word ----
  alu_ctrl_decode u_decode (
    .instr (instr),
    .dec   (dec_p0)
  );

  assign push = in_valid & in_ready_p1;
  assign pop  = vld_p1 & out_ready;

  always_comb begin
    count_nxt = count_p1;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count_p1 + 2'd1;
        2'b01:   count_nxt = count_p1 - 2'd1;
        default: count_nxt = count_p1;
      endcase
    end
  end

  // ---- stage 1: skid buffer; data cleared on reset so outputs read 0 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_p1[0]   <= '0;
      buf_p1[1]   <= '0;
      head_p1     <= 1'b0;
      tail_p1     <= 1'b0;
      count_p1    <= 2'd0;
      in_ready_p1 <= 1'b1;
      vld_p1      <= 1'b0;
    end else begin
      count_p1    <= count_nxt;
      in_ready_p1 <= (count_nxt != FULL);
      vld_p1      <= (count_nxt != 2'd0);
      if (flush) begin
        head_p1 <= 1'b0;
        tail_p1 <= 1'b0;
      end else begin
        if (push) begin
          buf_p1[tail_p1] <= dec_p0;
          tail_p1         <= ~tail_p1;
        end
        if (pop) begin
          head_p1 <= ~head_p1;
        end
      end
    end
  end

  assign head      = buf_p1[head_p1];
  assign in_ready  = in_ready_p1;
  assign out_valid = vld_p1;
  assign alufn     = head.alufn;
  assign sel_imm   = head.sel_imm;
  assign sel_pc    = head.sel_pc;
  assign imm       = head.imm;
  assign rs1_addr  = head.rs1_addr;
  assign rs2_addr  = head.rs2_addr;
  assign rd_addr   = head.rd_addr;
  assign reg_we    = head.reg_we;
  assign illegal   = head.illegal;

endmodule
